// File: rtl/mux_2to1_stream_arb.sv
// Two-source valid/ready merge with round-robin grant and a registered output slice.
// Define MUX2_PKT_LOCK_EN to hold the grant on one source until its packet ends.
module mux_2to1_stream_arb #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_last,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_last,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_src,
  input  logic          out_ready
);

  logic space;
  logic load;
  logic rr;
  logic grant;
  logic gvalid;
  logic glast;
  logic lg_upd;
  logic last_grant;

  assign space  = ~out_valid | out_ready;
  assign rr     = (in0_valid & in1_valid) ? ~last_grant
                                          : in1_valid;
  assign gvalid = grant ? in1_valid : in0_valid;
  assign glast  = grant ? in1_last : in0_last;
  assign load   = en & space & gvalid;

  assign in0_ready = load & ~grant;
  assign in1_ready = load & grant;

`ifdef MUX2_PKT_LOCK_EN
  typedef enum logic [1:0] {
    ARB,
    LOCK0,
    LOCK1
  } state_t;

  state_t state;
  state_t state_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nx;
  end

  // A locked source keeps the grant even while it is idle.
  always_comb begin
    state_nx = state;
    grant    = rr;
    unique case (1'b1)
      state == LOCK0: grant = 1'b0;
      state == LOCK1: grant = 1'b1;
      default:        grant = rr;
    endcase
    if (load) begin
      if (glast)      state_nx = ARB;
      else if (grant) state_nx = LOCK1;
      else            state_nx = LOCK0;
    end
  end

  assign lg_upd = load & glast;
`else
  assign grant  = rr;
  assign lg_upd = load;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= grant ? in1_data : in0_data;
        out_last  <= glast;
        out_src   <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (lg_upd) last_grant <= grant;
    end
  end

endmodule

// File: tb/tb_mux_2to1_stream_arb.sv
// Bench for mux_2to1_stream_arb: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mux_2to1_stream_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in0_valid;
  logic [7:0] in0_data;
  logic       in0_last;
  logic       in0_ready;
  logic       in1_valid;
  logic [7:0] in1_data;
  logic       in1_last;
  logic       in1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_src;
  logic       out_ready;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_2to1_stream_arb #(.DW(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in0_valid(in0_valid), .in0_data(in0_data),
    .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data),
    .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_last = 1'b1; in1_last = 1'b1;
    in0_data = 8'h00; in1_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; out_ready = 1'b1;
    in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = 8'h5a; in1_data = 8'ha5;
    in0_last = 1'b1; in1_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_run++;
    if (out_valid !== 1'b0 || out_src !== 1'b0 ||
        out_data !== 8'h00 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b src=%b data=%h last=%b want 0 0 00 0",
               out_valid, out_src, out_data, out_last);
    end
    rst = 1'b0;
    #1;
    n_run++;
    if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_en0: r0=%b r1=%b want 0 0",
               in0_ready, in1_ready);
    end
    @(posedge clk); #1;
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_en0_noload: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h11; in0_last = 1'b1;
    #1;
    n_run++;
    if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready: r0=%b r1=%b want 1 0",
               in0_ready, in1_ready);
    end
    @(posedge clk); #1;
    n_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 1'b0) begin
      n_fail++;
      $display("FAIL single_out: v=%b d=%h s=%b want 1 11 0",
               out_valid, out_data, out_src);
    end
    @(negedge clk);
    in0_valid = 1'b0;
    @(posedge clk); #1;
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] wd;
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'ha0;
    in1_valid = 1'b1; in1_data = 8'hb1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_run++;
      if (in0_ready !== (i % 2 == 0) || in1_ready !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: r0=%b r1=%b", i, in0_ready, in1_ready);
      end
      @(posedge clk); #1;
      wd = (i % 2 == 0) ? 8'ha0 : 8'hb1;
      n_run++;
      if (out_valid !== 1'b1 || out_src !== 1'(i % 2) ||
          out_data !== wd) begin
        n_fail++;
        $display("FAIL rr_out[%0d]: v=%b s=%b d=%h want 1 %0d %h",
                 i, out_valid, out_src, out_data, i % 2, wd);
      end
      @(negedge clk);
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 8'h44;
    @(negedge clk);
    in0_data = 8'h55;
    in1_valid = 1'b1; in1_data = 8'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_run++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: r0=%b r1=%b want 0 0",
                 i, in0_ready, in1_ready);
      end
      @(posedge clk); #1;
      n_run++;
      if (out_valid !== 1'b1 || out_data !== 8'h44 || out_src !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: v=%b d=%h s=%b want 1 44 0",
                 i, out_valid, out_data, out_src);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_run++;
    if (in0_ready !== 1'b0 || in1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: r0=%b r1=%b want 0 1",
               in0_ready, in1_ready);
    end
    @(posedge clk); #1;
    n_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h66 || out_src !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_out: v=%b d=%h s=%b want 1 66 1",
               out_valid, out_data, out_src);
    end
    @(negedge clk);
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_en_drain();
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 8'h77;
    @(negedge clk);
    en = 1'b0; out_ready = 1'b1;
    in1_valid = 1'b1; in1_data = 8'h88;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_run++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL en0_ready[%0d]: r0=%b r1=%b want 0 0",
                 i, in0_ready, in1_ready);
      end
      @(posedge clk); #1;
      n_run++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL en0_drain[%0d]: out_valid=%b want 0", i, out_valid);
      end
      @(negedge clk);
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_packet();
    int idx = 0;
    int got = 0;
    logic [3:0] seq = 4'h0;
    logic [3:0] want;
`ifdef MUX2_PKT_LOCK_EN
    want = 4'b1000;
`else
    want = 4'b1010;
`endif
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    in1_valid = 1'b1; in1_data = 8'hc0; in1_last = 1'b1;
    for (int c = 0; c < 12 && got < 4; c++) begin
      in0_valid = (idx < 3);
      in0_data  = 8'(idx + 1);
      in0_last  = (idx == 2);
      #1;
      if (in0_valid && in0_ready) idx++;
      @(posedge clk); #1;
      if (out_valid) begin
        seq[got] = out_src;
        got++;
      end
      @(negedge clk);
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    n_run++;
    if (got != 4 || seq !== want) begin
      n_fail++;
      $display("FAIL packet_seq: beats=%0d src(lsb first)=%b want 4 %b",
               got, seq, want);
    end
  endtask

  task automatic test_random();
    bit         m_valid = 0;
    bit   [7:0] m_data = 0;
    bit         m_last = 0;
    bit         m_src = 0;
    int         m_lg = 1;
    int         m_lock = -1;
    int         want;
    bit         space;
    bit         wlast;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst       = (i == 300);
      en        = ($urandom_range(9) < 8);
      out_ready = ($urandom_range(9) < 7);
      in0_valid = ($urandom_range(9) < 6);
      in1_valid = ($urandom_range(9) < 6);
      in0_data  = 8'($urandom);
      in1_data  = 8'($urandom);
      in0_last  = ($urandom_range(3) == 0);
      in1_last  = ($urandom_range(3) == 0);
      #1;
      space = !m_valid || out_ready;
      if (m_lock >= 0)
        want = ((m_lock == 0) ? in0_valid : in1_valid) ? m_lock : -1;
      else if (in0_valid && in1_valid) want = 1 - m_lg;
      else if (in0_valid)              want = 0;
      else if (in1_valid)              want = 1;
      else                             want = -1;
      if (!(en && space)) want = -1;
      if (!rst) begin
        n_run++;
        if ((in0_valid & in0_ready) !== (want == 0) ||
            (in1_valid & in1_ready) !== (want == 1) ||
            (in0_ready & in1_ready) !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_accept[%0d]: r0=%b r1=%b v0=%b v1=%b want_src=%0d",
                   i, in0_ready, in1_ready, in0_valid, in1_valid, want);
        end
      end
      if (rst) begin
        m_valid = 0; m_data = 0; m_last = 0; m_src = 0;
        m_lg = 1; m_lock = -1;
      end else if (want >= 0) begin
        wlast   = (want == 0) ? in0_last : in1_last;
        m_valid = 1;
        m_data  = (want == 0) ? in0_data : in1_data;
        m_last  = wlast;
        m_src   = (want == 1);
`ifdef MUX2_PKT_LOCK_EN
        if (wlast) begin
          m_lg = want; m_lock = -1;
        end else begin
          m_lock = want;
        end
`else
        m_lg = want;
`endif
      end else if (out_ready) begin
        m_valid = 0;
      end
      @(posedge clk); #1;
      n_run++;
      if (out_valid !== m_valid ||
          (m_valid && (out_data !== m_data || out_src !== m_src ||
                       out_last !== m_last))) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: v=%b d=%h s=%b l=%b want %b %h %b %b",
                 i, out_valid, out_data, out_src, out_last,
                 m_valid, m_data, m_src, m_last);
      end
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_en_drain();
    test_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
